// File: rtl/alu_arbiter.sv
// Arbitrates two valid/ready requesters onto one shared combinational ALU and returns the result.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              resp0_valid,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic              busy,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_in_a,
  output logic [DATA_W-1:0] alu_in_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            state_q, state_d;
  logic              winner_q, winner_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              prio0;
  logic              pick0;
  logic              grant0, grant1;

`ifdef ALU_ARB_RR_EN
  // last_q == 1 means requester 1 was granted last, so requester 0 wins the next contention.
  logic last_q, last_d;
  assign prio0 = last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

  always_comb begin
    last_d = last_q;
    if (grant0 || grant1) last_d = grant1;
  end
`else
  assign prio0 = 1'b1;
`endif

  assign pick0 = req0_valid & (~req1_valid | prio0);

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    zero_d   = zero_q;
    grant0   = 1'b0;
    grant1   = 1'b0;
    case (state_q)
      StIdle: begin
        if (req0_valid || req1_valid) begin
          grant0   = pick0;
          grant1   = ~pick0;
          winner_d = ~pick0;
          op_d     = pick0 ? req0_op : req1_op;
          a_d      = pick0 ? req0_a  : req1_a;
          b_d      = pick0 ? req0_b  : req1_b;
          state_d  = StExec;
        end
      end
      StExec: begin
        result_d = alu_result;
        zero_d   = alu_zero;
        state_d  = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      winner_q <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  // Readies are combinational from valid, so mask them while reset is asserted.
  assign req0_ready  = grant0 & ~rst;
  assign req1_ready  = grant1 & ~rst;
  assign resp0_valid = (state_q == StResp) & ~winner_q;
  assign resp1_valid = (state_q == StResp) & winner_q;
  assign busy        = (state_q != StIdle);
  assign alu_op      = op_q;
  assign alu_in_a    = a_q;
  assign alu_in_b    = b_q;
  assign resp_result = result_q;
  assign resp_zero   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter with a transaction-level reference model.
module tb_alu_arbiter;

`ifdef ALU_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  op0 = '0, op1 = '0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        resp0_valid, resp1_valid, resp_zero, busy;
  logic [31:0] resp_result;
  logic [3:0]  alu_op;
  logic [31:0] alu_in_a, alu_in_b, alu_result, alu_ref;
  logic        alu_zero;
  logic [31:0] noise = '0;
  logic        exec;

  int n_checks = 0;
  int n_fail   = 0;
  int last_grant = 1;
  int grants[$];

  always #5 clk = ~clk;
  always @(posedge clk) noise <= $urandom;

  function automatic logic [31:0] alu_fn(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  // The ALU output is only trustworthy during EXEC; elsewhere it is scrambled to expose bad captures.
  assign exec       = busy & ~resp0_valid & ~resp1_valid;
  assign alu_ref    = alu_fn(alu_op, alu_in_a, alu_in_b);
  assign alu_result = exec ? alu_ref : (alu_ref ^ noise);
  assign alu_zero   = (alu_result == 32'd0);

  alu_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(op0), .req0_a(a0), .req0_b(b0),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(op1), .req1_a(a1), .req1_b(b1),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_result(resp_result),
    .resp_zero(resp_zero), .busy(busy), .alu_op(alu_op), .alu_in_a(alu_in_a),
    .alu_in_b(alu_in_b), .alu_result(alu_result), .alu_zero(alu_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic new_payload(input int n);
    logic [3:0]  op = 4'($urandom_range(0, 5));
    logic [31:0] a  = $urandom;
    logic [31:0] b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
    if (n == 0) begin op0 = op; a0 = a; b0 = b; end
    else        begin op1 = op; a1 = a; b1 = b; end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy0"}, 32'(req0_ready), 32'd0);
    check({tag, "_rdy1"}, 32'(req1_ready), 32'd0);
    check({tag, "_resp0"}, 32'(resp0_valid), 32'd0);
    check({tag, "_resp1"}, 32'(resp1_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_aluop"}, 32'(alu_op), 32'd0);
    check({tag, "_alua"}, alu_in_a, 32'd0);
    check({tag, "_alub"}, alu_in_b, 32'd0);
    check({tag, "_res"}, resp_result, 32'd0);
    check({tag, "_zero"}, 32'(resp_zero), 32'd0);
  endtask

  // Starts at a negedge in IDLE; ends at the negedge of the following IDLE cycle.
  task automatic run_op(input bit v0, input bit v1);
    int          w;
    logic [3:0]  eop;
    logic [31:0] ea, eb, er;
    req0_valid = v0;
    req1_valid = v1;
    #1;
    if (!v0 && !v1) begin
      check("idle_rdy0", 32'(req0_ready), 32'd0);
      check("idle_rdy1", 32'(req1_ready), 32'd0);
      @(negedge clk);
      return;
    end
    if (v0 && v1) w = RrEn ? (last_grant == 0 ? 1 : 0) : 0;
    else          w = v1 ? 1 : 0;
    check("acc_rdy0", 32'(req0_ready), 32'(w == 0));
    check("acc_rdy1", 32'(req1_ready), 32'(w == 1));
    check("acc_busy", 32'(busy), 32'd0);
    eop = (w == 0) ? op0 : op1;
    ea  = (w == 0) ? a0 : a1;
    eb  = (w == 0) ? b0 : b1;
    er  = alu_fn(eop, ea, eb);
    last_grant = w;
    grants.push_back(w);
    @(negedge clk);
    check("exec_busy", 32'(busy), 32'd1);
    check("exec_op", 32'(alu_op), 32'(eop));
    check("exec_a", alu_in_a, ea);
    check("exec_b", alu_in_b, eb);
    check("exec_rdy", 32'({req0_ready, req1_ready}), 32'd0);
    check("exec_resp", 32'({resp0_valid, resp1_valid}), 32'd0);
    new_payload(w);
    @(negedge clk);
    check("resp_v0", 32'(resp0_valid), 32'(w == 0));
    check("resp_v1", 32'(resp1_valid), 32'(w == 1));
    check("resp_res", resp_result, er);
    check("resp_zero", 32'(resp_zero), 32'(er == 32'd0));
    check("resp_busy", 32'(busy), 32'd1);
    check("resp_rdy", 32'({req0_ready, req1_ready}), 32'd0);
    @(negedge clk);
    check("post_resp", 32'({resp0_valid, resp1_valid}), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("hold_res", resp_result, er);
  endtask

  initial begin
    // Reset with both requesters valid: readies must stay masked.
    new_payload(0);
    new_payload(1);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #12;
    check_all_zero("rst");
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    op0 = 4'd0; a0 = 32'h5; b0 = 32'h3;
    run_op(1'b1, 1'b0);
    op1 = 4'd1; a1 = 32'hDEADBEEF; b1 = 32'hDEADBEEF;
    run_op(1'b0, 1'b1);

    grants.delete();
    repeat (4) run_op(1'b1, 1'b1);
    for (int i = 0; i < 4; i++)
      check("contention_grant", 32'(grants[i]), RrEn ? 32'(i % 2) : 32'd0);

    repeat (4) run_op(1'b1, 1'b0);
    repeat (40) run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Reset during EXEC after requester 0 was granted last.
    new_payload(0);
    req0_valid = 1'b1;
    req1_valid = 1'b0;
    #1;
    check("mid_acc", 32'(req0_ready), 32'd1);
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    req1_valid = 1'b1;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    check_all_zero("midrst_hold");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    last_grant = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_resp", 32'({resp0_valid, resp1_valid, busy}), 32'd0);
    end
    grants.delete();
    run_op(1'b1, 1'b1);
    check("post_rst_grant", 32'(grants[0]), 32'd0);

    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

- Shares one combinational 32-bit ALU between two requesters (e.g. core datapath and a debug/test port) using a valid/ready handshake.
- Registers the winning operands onto the ALU inputs, captures the ALU result and zero flag, and returns them to the winner with a one-cycle response pulse.
- Sits directly in front of the ALU; the ALU's op/in_a/in_b/result/zero signals connect to this block's alu_* ports.

## Interface
- DATA_W, 32, operand/result width; must match the ALU.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req0_valid / req1_valid  input  1  requester n has an operation pending.
- req0_ready / req1_ready  output  1  operation from requester n accepted this cycle.
- req0_op / req1_op  input  4  ALU opcode, passed through opaque.
- req0_a, req0_b / req1_a, req1_b  input  DATA_W  operands.
- resp0_valid / resp1_valid  output  1  one-cycle pulse: result for requester n is valid.
- resp_result  output  DATA_W  captured ALU result.
- resp_zero  output  1  captured ALU zero flag.
- busy  output  1  high in EXEC and RESP.
- alu_op  output  4  registered opcode to the ALU.
- alu_in_a, alu_in_b  output  DATA_W  registered operands to the ALU.
- alu_result  input  DATA_W  ALU result, combinational from alu_*.
- alu_zero  input  1  ALU zero flag.

## Operation
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if either valid, select winner, assert winner's ready combinationally, latch op/a/b into alu_* registers, record winner id, go to EXEC. Otherwise stay in IDLE.
  - EXEC: alu_* held stable. At the clock edge, capture alu_result/alu_zero into resp_result/resp_zero and go to RESP.
  - RESP: resp<winner>_valid high for exactly this cycle, then go to IDLE.
- ready is asserted only in IDLE, to at most one requester, and only while that requester's valid is high.
- Requester rule: once valid rises, valid and payload stay stable until ready; the block does not check this.
- Arbitration when both are valid in IDLE: see Configuration. A single valid requester always wins.
- alu_*, resp_result and resp_zero hold their last values outside capture cycles.
- Reset: state IDLE; all outputs 0 (readies, resp valids, busy, alu_op, alu_in_a, alu_in_b, resp_result, resp_zero); winner id 0; last-grant pointer 1, so requester 0 wins the first contention.
- Reset mid-operation: the in-flight operation is discarded and no response pulse is produced.

## Timing
- Accept at cycle N (ready and valid both high); alu_* valid from N+1; resp_valid high in cycle N+2.
- Throughput: one operation per 3 cycles.
- A new request can be accepted in the cycle after RESP at the earliest.
- Requester n may drop valid in the cycle after its ready.
- A valid that stays high after acceptance is treated as a new request in the next IDLE.

## Configuration
- ALU_ARB_RR_EN defined: round-robin arbitration.
  - On contention, grant the requester not granted last; the last-grant pointer updates on every accept.
- ALU_ARB_RR_EN undefined: fixed priority.
  - Requester 0 always wins contention.
  - The last-grant pointer is not implemented.

## Test plan
- Single request: req0 op=ALU add, a=32'h5, b=32'h3 -> req0_ready at N, resp0_valid only at N+2, resp_result=32'h8, resp_zero=0, busy high N+1..N+2.
- Zero flag: req1 op=ALU sub, a=b=32'hDEADBEEF -> resp1_valid at N+2, resp_result=0, resp_zero=1, resp0_valid never high.
- Contention: both valid and held for 4 operations.
  - With ALU_ARB_RR_EN: grants 0,1,0,1.
  - Without: grants 0,0,0,0 while req1 starves.
- Back-to-back: req0 holds valid with new payloads -> accepts every 3 cycles, never two readies within 3 cycles, results in order.
- Reset mid-op: assert rst during EXEC -> all outputs 0 immediately (asynchronous), no resp pulse; after release, the first contention grants requester 0.
- Hold check: change alu_result stimulus outside the EXEC capture edge -> resp_result unchanged.
